// File: rtl/count_n_bit_pkg.sv
// Shared constants for the count_n_bit utility counter.
// Holds the default width so every instantiation agrees on it.
package count_n_bit_pkg;

    localparam int DEFAULT_N_BIT = 4;
    localparam int MIN_N_BIT     = 1;
    localparam int MAX_N_BIT     = 32;

endpackage : count_n_bit_pkg

// File: rtl/count_n_bit.sv
// Free-running N_BIT binary up-counter with synchronous active-high clear.
// The count output comes straight from the state register.
module count_n_bit
    import count_n_bit_pkg::*;
#(
    parameter int N_BIT = DEFAULT_N_BIT
) (
    input  logic             clk,
    input  logic             rst,
    output logic [N_BIT-1:0] count
);

    // Declaration initialiser makes the count defined (zero) before any reset.
    logic [N_BIT-1:0] count_q = '0;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule : count_n_bit

// File: tb/tb_count_n_bit.sv
// Scoreboard bench for count_n_bit at widths 4, 1 and 8 sharing one clk/rst.
// The reference model is modular arithmetic on plain ints.
`timescale 1ps/1ps
module tb_count_n_bit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] count4;
    logic [0:0] count1;
    logic [7:0] count8;

    count_n_bit #(.N_BIT(4)) dut4 (.clk(clk), .rst(rst), .count(count4));
    count_n_bit #(.N_BIT(1)) dut1 (.clk(clk), .rst(rst), .count(count1));
    count_n_bit              dut8 (.clk(clk), .rst(rst), .count(count8));
    defparam dut8.N_BIT = 8;

    always #500 clk = ~clk;

    typedef struct {
        int e4;
        int e1;
        int e8;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   stim_done = 1'b0;

    // Model state: value each counter should hold after the most recent edge.
    int m4 = 0;
    int m1 = 0;
    int m8 = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the value after the coming edge, given the rst level sampled there.
    task automatic predict(input bit r);
        exp_t e;
        m4 = r ? 0 : (m4 + 1) % 16;
        m1 = r ? 0 : (m1 + 1) % 2;
        m8 = r ? 0 : (m8 + 1) % 256;
        e.e4 = m4;
        e.e1 = m1;
        e.e8 = m8;
        exp_q.push_back(e);
    endtask

    // Drive rst for the next edge; optionally pulse rst between edges afterwards.
    task automatic step(input bit r, input bit glitch);
        @(negedge clk);
        rst = r;
        predict(r);
        if (glitch) begin
            @(posedge clk);
            #200 rst = 1'b1;
            #100 rst = 1'b0;
        end
    endtask

    // Monitor: after every rising edge, compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("count4", int'(count4), e.e4);
                check("count1", int'(count1), e.e1);
                check("count8", int'(count8), e.e8);
            end
        end
    end

    // Stimulus
    initial begin
        #1;
        check("power_up4", int'(count4), 0);
        check("power_up1", int'(count1), 0);
        check("power_up8", int'(count8), 0);
        predict(1'b0);                      // first edge at 500 ps, rst low

        // Free run through the 4-bit wrap: 17 edges total including the first.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0);

        // Mid-run reset across one edge, then resume.
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Sustained reset for 5 edges.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Reach 15 from zero, then reset on the terminal-value edge.
        step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);

        // Glitches between edges are never sampled.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);

        // Randomised reset pattern.
        for (int i = 0; i < 400; i++) step($urandom_range(0, 7) == 0, 1'b0);

        // Clean run long enough to wrap the 8-bit counter.
        step(1'b1, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b0, 1'b0);

        step(1'b0, 1'b0);
        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then summarise.
    initial begin
        int budget;
        wait (stim_done);
        budget = 0;
        while (exp_q.size() != 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #10;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_count_n_bit
